// File: rtl/lif_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

    localparam int SHIFT_W = 3;
    localparam int SAT_W   = 32;

    typedef enum logic {
        LIF_IDLE   = 1'b0,
        LIF_UPDATE = 1'b1
    } lif_state_t;

    // Unsigned add clamped to 2^w - 1; w must be below SAT_W.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               w
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
        if (sum > lim) begin
            sat_add = lim[SAT_W-1:0];
        end else begin
            sat_add = sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron step: refractory countdown, shift leak,
// saturating integration and threshold fire.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int REFRAC_W = 3
) (
    input  logic [WIDTH-1:0]    u,
    input  logic [REFRAC_W-1:0] rc,
    input  logic [WIDTH-1:0]    current_in,
    input  logic [SHIFT_W-1:0]  shift,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [REFRAC_W-1:0] refrac_len,
    output logic [WIDTH-1:0]    u_next,
    output logic [REFRAC_W-1:0] rc_next,
    output logic                spike
);

    logic [WIDTH-1:0] u_shr;
    logic [WIDTH-1:0] beta;
    logic [SAT_W-1:0] sum;

    // u - (u >> shift) as a two's-complement add; shift=0 leaks to zero.
    assign u_shr = u >> shift;
    assign beta  = u + ~u_shr + WIDTH'(1);
    assign sum   = sat_add(SAT_W'(beta), SAT_W'(current_in), WIDTH);

    always_comb begin
        u_next  = '0;
        rc_next = '0;
        spike   = 1'b0;
        if (rc != '0) begin
            rc_next = rc - REFRAC_W'(1);
        end else if (sum >= SAT_W'(threshold)) begin
            spike   = 1'b1;
            rc_next = refrac_len;
        end else begin
            u_next = sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: one neuron updated per clock during a
// sweep, spikes emitted in index order.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int WIDTH     = 12,
    parameter int REFRAC_W  = 3,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_start,
    input  logic [SHIFT_W-1:0]  shift,
    input  logic [WIDTH-1:0]    threshold,
    input  logic [REFRAC_W-1:0] refrac_len,
    output logic [IDX_W-1:0]    cur_idx,
    input  logic [WIDTH-1:0]    current_in,
    output logic                busy,
    output logic                done,
    output logic                spike_valid,
    output logic [IDX_W-1:0]    spike_idx,
    input  logic [IDX_W-1:0]    u_rd_idx,
    output logic [WIDTH-1:0]    u_rd_data
);

    lif_state_t          state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [SHIFT_W-1:0]  shift_reg;
    logic [WIDTH-1:0]    thr_reg;
    logic [REFRAC_W-1:0] refrac_reg;
    logic                done_reg;
    logic                spike_valid_reg;
    logic [IDX_W-1:0]    spike_idx_reg;

    logic [WIDTH-1:0]    u_arr  [N_NEURONS];
    logic [REFRAC_W-1:0] rc_arr [N_NEURONS];

    logic                accept;
    logic                last;
    logic [WIDTH-1:0]    u_next;
    logic [REFRAC_W-1:0] rc_next;
    logic                spike;

    assign busy = (state_reg == LIF_UPDATE);
    assign last = (idx_reg == IDX_W'(N_NEURONS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LIF_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            LIF_IDLE: begin
                if (step_start) begin
                    state_next = LIF_UPDATE;
                    accept     = 1'b1;
                end
            end
            LIF_UPDATE: begin
                if (last) begin
                    state_next = LIF_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg         <= '0;
            shift_reg       <= '0;
            thr_reg         <= '0;
            refrac_reg      <= '0;
            done_reg        <= 1'b0;
            spike_valid_reg <= 1'b0;
            spike_idx_reg   <= '0;
        end else begin
            done_reg        <= busy && last;
            spike_valid_reg <= busy && spike;
            if (busy && spike) begin
                spike_idx_reg <= idx_reg;
            end
            if (accept) begin
                idx_reg    <= '0;
                shift_reg  <= shift;
                thr_reg    <= threshold;
                refrac_reg <= refrac_len;
            end else if (busy) begin
                idx_reg <= last ? '0 : idx_reg + IDX_W'(1);
            end
        end
    end

    lif_update #(
        .WIDTH    (WIDTH),
        .REFRAC_W (REFRAC_W)
    ) u_update (
        .u          (u_arr[idx_reg]),
        .rc         (rc_arr[idx_reg]),
        .current_in (current_in),
        .shift      (shift_reg),
        .threshold  (thr_reg),
        .refrac_len (refrac_reg),
        .u_next     (u_next),
        .rc_next    (rc_next),
        .spike      (spike)
    );

    // Each neuron owns its own state registers so reset can clear all at once.
    genvar gi;
    generate
        for (gi = 0; gi < N_NEURONS; gi++) begin : g_cell
            logic [WIDTH-1:0]    u_reg;
            logic [REFRAC_W-1:0] rc_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    u_reg  <= '0;
                    rc_reg <= '0;
                end else if (busy && (idx_reg == IDX_W'(gi))) begin
                    u_reg  <= u_next;
                    rc_reg <= rc_next;
                end
            end

            assign u_arr[gi]  = u_reg;
            assign rc_arr[gi] = rc_reg;
        end
    endgenerate

    assign cur_idx     = idx_reg;
    assign done        = done_reg;
    assign spike_valid = spike_valid_reg;
    assign spike_idx   = spike_idx_reg;
    assign u_rd_data   = u_arr[u_rd_idx];

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed and randomized sweeps of lif_neuron_array against an arithmetic
// reference model of the neuron rules.
`timescale 1ns/1ps
module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int R  = 3;
    localparam int IW = 2;
    localparam int UMAX = (1 << W) - 1;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          step_start = 1'b0;
    logic [2:0]    shift      = '0;
    logic [W-1:0]  threshold  = '0;
    logic [R-1:0]  refrac_len = '0;
    logic [IW-1:0] cur_idx;
    logic [W-1:0]  current_in = '0;
    logic          busy;
    logic          done;
    logic          spike_valid;
    logic [IW-1:0] spike_idx;
    logic [IW-1:0] u_rd_idx   = '0;
    logic [W-1:0]  u_rd_data;

    always #10 clk = ~clk;

    lif_neuron_array #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .REFRAC_W  (R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step_start  (step_start),
        .shift       (shift),
        .threshold   (threshold),
        .refrac_len  (refrac_len),
        .cur_idx     (cur_idx),
        .current_in  (current_in),
        .busy        (busy),
        .done        (done),
        .spike_valid (spike_valid),
        .spike_idx   (spike_idx),
        .u_rd_idx    (u_rd_idx),
        .u_rd_data   (u_rd_data)
    );

    int total  = 0;
    int passes = 0;
    int mu      [N];
    int mrc     [N];
    int cur_tab [N];
    bit exp_spk [N];
    int leak_exp [3] = '{100, 175, 232};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mu[n]  = 0;
            mrc[n] = 0;
        end
    endtask

    // One sweep of the neuron rules with the parameters currently driven.
    task automatic model_sweep();
        int sh, thr, rl, beta, s;
        sh  = int'(shift);
        thr = int'(threshold);
        rl  = int'(refrac_len);
        for (int n = 0; n < N; n++) begin
            exp_spk[n] = 1'b0;
            if (mrc[n] != 0) begin
                mu[n]  = 0;
                mrc[n] = mrc[n] - 1;
            end else begin
                beta = mu[n] - (mu[n] >> sh);
                s    = beta + cur_tab[n];
                if (s > UMAX) s = UMAX;
                if (s >= thr) begin
                    exp_spk[n] = 1'b1;
                    mu[n]      = 0;
                    mrc[n]     = rl;
                end else begin
                    mu[n] = s;
                end
            end
        end
    endtask

    task automatic check_all_u(input string tag);
        for (int n = 0; n < N; n++) begin
            u_rd_idx = IW'(n);
            #1;
            chk(tag, 32'(u_rd_data), 32'(mu[n]));
        end
    endtask

    task automatic chk_spike(input int n);
        chk("spike_valid", 32'(spike_valid), 32'(exp_spk[n]));
        if (exp_spk[n]) chk("spike_idx", 32'(spike_idx), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic sweep(input bit started, input bit chain_next, input bit poke_mid);
        model_sweep();
        if (!started) begin
            @(negedge clk);
            step_start = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            step_start = poke_mid && (i == 1);
            current_in = W'(cur_tab[i]);
            chk("busy", 32'(busy), 1);
            chk("cur_idx", 32'(cur_idx), 32'(i));
            if (i > 0) chk_spike(i - 1);
        end
        @(negedge clk);
        step_start = chain_next;
        chk("busy_end", 32'(busy), 0);
        chk("done", 32'(done), 1);
        chk_spike(N - 1);
        check_all_u("u_after_sweep");
    endtask

    task automatic set_all_cur(input int v);
        for (int n = 0; n < N; n++) cur_tab[n] = v;
    endtask

    initial begin
        model_reset();
        set_all_cur(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_spike", 32'(spike_valid), 0);
        chk("rst_cur_idx", 32'(cur_idx), 0);
        check_all_u("rst_u");

        // Leak and integrate
        shift = 3'd2; threshold = 12'd4000; refrac_len = 3'd0;
        set_all_cur(100);
        for (int k = 0; k < 3; k++) begin
            sweep(1'b0, 1'b0, 1'b0);
            u_rd_idx = '0;
            #1;
            chk("leak_u0", 32'(u_rd_data), 32'(leak_exp[k]));
        end

        // Reset while idle clears stored potentials
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("idle_rst_busy", 32'(busy), 0);
        chk("idle_rst_done", 32'(done), 0);
        chk("idle_rst_spike", 32'(spike_valid), 0);
        model_reset();
        check_all_u("idle_rst_u");
        rst = 1'b0;

        // Fire and refractory on neuron 2
        threshold = 12'd200; refrac_len = 3'd2; shift = 3'd2;
        set_all_cur(0);
        cur_tab[2] = 256;
        for (int k = 0; k < 4; k++) sweep(1'b0, 1'b0, 1'b0);

        // Saturation
        do_reset();
        shift = 3'd7; threshold = 12'd4095; refrac_len = 3'd0;
        set_all_cur(3000);
        sweep(1'b0, 1'b0, 1'b0);
        sweep(1'b0, 1'b0, 1'b0);

        // Handshake: ignored mid-sweep request, then back-to-back sweeps
        shift = 3'd0; threshold = 12'd4000; refrac_len = 3'd0;
        set_all_cur(50);
        sweep(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("poke_ignored_busy", 32'(busy), 0);
        chk("poke_ignored_done", 32'(done), 0);
        sweep(1'b0, 1'b1, 1'b0);
        sweep(1'b1, 1'b1, 1'b0);
        sweep(1'b1, 1'b0, 1'b0);
        u_rd_idx = 2'd3;
        #1;
        chk("full_leak_u3", 32'(u_rd_data), 50);

        // Asynchronous reset in the middle of a sweep
        threshold = 12'd0; shift = 3'd2;
        set_all_cur(500);
        @(negedge clk);
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        current_in = W'(500);
        chk("ar_cur_idx0", 32'(cur_idx), 0);
        @(negedge clk);
        chk("ar_cur_idx1", 32'(cur_idx), 1);
        chk("ar_spike0", 32'(spike_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_cur_idx", 32'(cur_idx), 0);
        chk("ar_spike", 32'(spike_valid), 0);
        chk("ar_done", 32'(done), 0);
        model_reset();
        check_all_u("ar_u");
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ar_quiet_spike", 32'(spike_valid), 0);
            chk("ar_quiet_done", 32'(done), 0);
        end

        // Randomized sweeps
        for (int k = 0; k < 10; k++) begin
            shift      = 3'($urandom_range(0, 7));
            threshold  = 12'($urandom_range(0, 4095));
            refrac_len = 3'($urandom_range(0, 7));
            for (int n = 0; n < N; n++) cur_tab[n] = int'($urandom_range(0, 2500));
            sweep(1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of leaky integrate-and-fire neurons that carries the fixed-shift leak datapath forward. The leak is beta·u = u − (u >> shift), computed as u plus the inverted shifted value plus a carry-in of 1. The array adds:
- per-neuron membrane state storage
- an input current that is integrated into the potential
- threshold comparison and spike emission
- a programmable refractory period

A sweep updates one neuron per clock. The block sits between the synaptic current accumulator, which supplies current for the neuron currently indexed, and the spike router.

## Interface
- N_NEURONS, 8, number of neurons; must be ≥ 2.
- WIDTH, 12, potential, current and threshold width, unsigned.
- REFRAC_W, 3, refractory counter width.
- IDX_W, $clog2(N_NEURONS), neuron index width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- step_start  in  1  request one full sweep; honoured only while busy=0.
- shift  in  3  leak shift amount; sampled at accept.
- threshold  in  WIDTH  firing threshold; sampled at accept.
- refrac_len  in  REFRAC_W  refractory steps after a spike; sampled at accept.
- cur_idx  out  IDX_W  index of the neuron being updated; current_in must correspond to it.
- current_in  in  WIDTH  input current for neuron cur_idx; sampled every busy cycle.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- spike_valid  out  1  neuron spike_idx fired this step.
- spike_idx  out  IDX_W  index of the firing neuron.
- u_rd_idx  in  IDX_W  debug readback index.
- u_rd_data  out  WIDTH  stored potential of neuron u_rd_idx; combinational read.

## Operation
- State: u[N_NEURONS] (WIDTH bits each) and rc[N_NEURONS] (REFRAC_W bits each).
- FSM has two states, IDLE and UPDATE.
  - IDLE → UPDATE when step_start=1. shift, threshold and refrac_len are latched at that point, and idx is set to 0.
  - UPDATE → IDLE after the edge that writes neuron N_NEURONS−1.
- Per-neuron update, applied to neuron idx at each UPDATE edge:
  - If rc≠0: u←0, rc←rc−1, no spike, and current_in is ignored.
  - Otherwise:
    - Leak: beta = u − (u >> shift). With shift=0 this gives beta=0, i.e. full leak.
    - Integrate: sum = beta + current_in, computed at WIDTH+1 bits and saturated to 2^WIDTH−1.
    - Fire: if sum ≥ threshold, spike, u←0 and rc←refrac_len. Otherwise u←sum.
- threshold=0 means every non-refractory neuron fires on every step.
- refrac_len=0 means no refractory period.
- step_start while busy=1 is ignored; there is no queueing.
- u_rd_data reads the stored value. If u_rd_idx equals the neuron being updated, it returns the pre-update value until the write edge.
- Reset (asynchronous, any time, including mid-sweep):
  - All u and rc cleared to 0.
  - FSM returns to IDLE.
  - cur_idx, busy, done, spike_valid and spike_idx all go to 0.
  - Any partially completed sweep is discarded.

## Timing
- Edge E0 accepts step_start. From E0 to E_N: busy=1 and cur_idx=i during the cycle that precedes edge E(i+1).
- Edge E(i+1) writes neuron i and registers its spike. spike_valid/spike_idx=i is visible in the cycle after E(i+1), for exactly one cycle.
- After E_N: busy=0 and done=1 for one cycle. That cycle also carries the spike_valid of the last neuron.
- A step_start asserted during the done cycle is accepted, giving back-to-back sweeps of N_NEURONS+1 cycles each.
- Latency from step_start acceptance to done is N_NEURONS edges.
- Spike throughput is at most one per cycle, delivered in index order.

## Structure
- Package lif_pkg holds:
  - the FSM state enum (LIF_IDLE, LIF_UPDATE)
  - the saturating-add function
  - the SHIFT_W=3 constant
- One combinational sub-module, lif_update, computes u_next, rc_next and spike from u, rc, current_in, shift, threshold and refrac_len.
  - The leak is implemented as u + ~(u >> shift) + 1.
  - It is exhaustively checkable standalone.
- The top level contains the FSM, the index counter, the state arrays and the output registers.

## Test plan
All scenarios use N_NEURONS=4, WIDTH=12, REFRAC_W=3.
- Reset: assert rst mid-idle → busy=0, done=0, spike_valid=0, u_rd_data=0 for all indices.
- Leak/integrate: shift=2, threshold=4000, current_in=100 for all neurons over 3 sweeps → u reads 100, then 175, then 232; no spikes.
- Fire and refractory: threshold=200, refrac_len=2, current_in=256 for idx 2 only → on sweep 1, spike_valid with spike_idx=2 three cycles after the accept edge, and u[2]=0. Sweeps 2–3 produce no spike and u[2]=0. Sweep 4 spikes again.
- Saturation: shift=7, threshold=4095, current_in=3000 → sweep 1 gives u=3000. Sweep 2 sums 2977+3000, saturating to 4095 → spike on every neuron and u=0.
- Handshake: step_start pulsed mid-sweep → ignored. step_start in the done cycle → accepted, and busy stays high for N_NEURONS cycles. shift=0 with current_in=50 → u=50 after every sweep.
- Async reset: rst at cur_idx=1 → neurons 0–3 all read 0, no further spikes, no done pulse.
